// File: rtl/seg_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seg_pkg                                                            |
// | Shared types and constants for the serial 7-segment display driver |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package seg_pkg;

    localparam int BYTE_W = 8;

    localparam logic [BYTE_W-1:0] SEG_OFF_HI = 8'hFF;
    localparam logic [BYTE_W-1:0] SEG_OFF_LO = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_LATCH = 2'd3
    } state_t;

    // Active-high {g,f,e,d,c,b,a} pattern for one hex digit.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        logic [6:0] seg;
        seg = 7'h00;
        case (hex)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
        endcase
        return seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_digit_enc.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seg_digit_enc                                                      |
// | Combinational encoder producing one display byte per digit         |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module seg_digit_enc
    import seg_pkg::*;
#(
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic [3:0]        hex,
    input  logic [BYTE_W-1:0] raw_byte,
    input  logic              point,
    input  logic              blank,
    input  logic              mode,
    output logic [BYTE_W-1:0] seg
);

    logic [BYTE_W-1:0] w_hex_hi;
    logic [BYTE_W-1:0] w_hex_byte;
    logic [BYTE_W-1:0] w_off;

    assign w_hex_hi   = {point, hex_to_seg(hex)};
    assign w_hex_byte = (SEG_ACTIVE_LOW != 0) ? ~w_hex_hi : w_hex_hi;
    assign w_off      = (SEG_ACTIVE_LOW != 0) ? SEG_OFF_HI : SEG_OFF_LO;

    // Raw bytes bypass polarity; blanking overrides both modes.
    assign seg = blank ? w_off : (mode ? raw_byte : w_hex_byte);

endmodule
`default_nettype wire

// File: rtl/seg_serial_display.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seg_serial_display                                                 |
// | Frame encoder and serial shifter for chained 7-segment registers   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module seg_serial_display
    import seg_pkg::*;
#(
    parameter int DIGITS         = 8,
    parameter int SCLK_DIV       = 2,
    parameter int DIR            = 1,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       mode,
    input  logic [4*DIGITS-1:0]        hexs,
    input  logic [DIGITS-1:0]          points,
    input  logic [DIGITS-1:0]          les,
    input  logic                       flash,
    input  logic [BYTE_W*DIGITS-1:0]   raw,
    output logic                       busy,
    output logic                       done,
    output logic                       segclk,
    output logic                       segsout,
    output logic                       segen,
    output logic                       segclrn
);

    localparam int N  = BYTE_W * DIGITS;
    localparam int BW = $clog2(N);
    localparam int DW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCLK_DIV - 1);

    state_t          r_state;
    logic            r_pending;
    logic [DW-1:0]   r_div;
    logic [BW-1:0]   r_bit;
    logic [N-1:0]    r_sr;

    logic [N-1:0]    w_frame;
    logic [N-1:0]    w_sr_next;
    logic            w_first;
    logic            w_next_bit;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        seg_digit_enc #(
            .SEG_ACTIVE_LOW (SEG_ACTIVE_LOW)
        ) u_enc (
            .hex      (hexs[4*gi +: 4]),
            .raw_byte (raw[BYTE_W*gi +: BYTE_W]),
            .point    (points[gi]),
            .blank    (les[gi] & flash),
            .mode     (mode),
            .seg      (w_frame[BYTE_W*gi +: BYTE_W])
        );
    end

    // The outgoing bit always sits at the exit end of the shift register.
    assign w_sr_next  = (DIR != 0) ? {r_sr[N-2:0], 1'b0} : {1'b0, r_sr[N-1:1]};
    assign w_first    = (DIR != 0) ? w_frame[N-1] : w_frame[0];
    assign w_next_bit = (DIR != 0) ? w_sr_next[N-1] : w_sr_next[0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_pending <= 1'b0;
            r_div     <= '0;
            r_bit     <= '0;
            r_sr      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            segclk    <= 1'b0;
            segsout   <= 1'b0;
            segen     <= 1'b1;
            segclrn   <= 1'b1;
        end else begin
            done <= 1'b0;
            if (start && (r_state != ST_IDLE)) begin
                r_pending <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (start || r_pending) begin
                        r_state   <= ST_LOAD;
                        r_pending <= 1'b0;
                        busy      <= 1'b1;
                        segclrn   <= 1'b0;
                        segen     <= 1'b0;
                    end
                end

                ST_LOAD: begin
                    r_sr    <= w_frame;
                    segsout <= w_first;
                    segclrn <= 1'b1;
                    segclk  <= 1'b0;
                    r_div   <= '0;
                    r_bit   <= '0;
                    r_state <= ST_SHIFT;
                end

                ST_SHIFT: begin
                    if (r_div == DIV_LAST) begin
                        r_div <= '0;
                        if (!segclk) begin
                            segclk <= 1'b1;
                        end else begin
                            segclk <= 1'b0;
                            // Counter parks on the last bit; nothing past the frame is emitted.
                            if (r_bit == BIT_LAST) begin
                                r_state <= ST_LATCH;
                                segen   <= 1'b1;
                                done    <= 1'b1;
                            end else begin
                                r_bit   <= r_bit + 1'b1;
                                r_sr    <= w_sr_next;
                                segsout <= w_next_bit;
                            end
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end

                ST_LATCH: begin
                    if (start || r_pending) begin
                        r_state   <= ST_LOAD;
                        r_pending <= 1'b0;
                        segclrn   <= 1'b0;
                        segen     <= 1'b0;
                    end else begin
                        r_state <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg_serial_display.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_seg_serial_display                                              |
// | Timeline reference model and directed/random stimulus, two configs |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_seg_serial_display;

    localparam int ND [2] = '{8, 4};
    localparam int DV [2] = '{2, 1};
    localparam int DR [2] = '{1, 0};
    localparam logic [6:0] SEGTAB [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        start0 = 0, mode0 = 0, flash0 = 0;
    logic [31:0] hexs0 = '0;
    logic [7:0]  points0 = '0, les0 = '0;
    logic [63:0] raw0 = '0;
    logic        busy0, done0, segclk0, segsout0, segen0, segclrn0;

    logic        start1 = 0, mode1 = 0, flash1 = 0;
    logic [15:0] hexs1 = '0;
    logic [3:0]  points1 = '0, les1 = '0;
    logic [31:0] raw1 = '0;
    logic        busy1, done1, segclk1, segsout1, segen1, segclrn1;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    int          k [2] = '{-1, -1};
    logic        pend [2] = '{1'b0, 1'b0};
    logic [63:0] frm [2];
    logic [63:0] cap [2];
    logic [63:0] last [2];
    int          cnt [2] = '{0, 0};
    int          ndone [2] = '{0, 0};
    int          done_cyc [2] = '{0, 0};
    logic        pclk [2] = '{1'b0, 1'b0};

    always #5 clk = ~clk;

    seg_serial_display u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .mode(mode0), .hexs(hexs0),
        .points(points0), .les(les0), .flash(flash0), .raw(raw0),
        .busy(busy0), .done(done0), .segclk(segclk0), .segsout(segsout0),
        .segen(segen0), .segclrn(segclrn0)
    );

    seg_serial_display #(
        .DIGITS(4), .SCLK_DIV(1), .DIR(0), .SEG_ACTIVE_LOW(1)
    ) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .mode(mode1), .hexs(hexs1),
        .points(points1), .les(les1), .flash(flash1), .raw(raw1),
        .busy(busy1), .done(done1), .segclk(segclk1), .segsout(segsout1),
        .segen(segen1), .segclrn(segclrn1)
    );

    task automatic check(input string name, input int d, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s dut=%0d cyc=%0d got=%h exp=%h", name, d, cyc, got, exp);
        end
    endtask

    function automatic logic [63:0] encode(input int nd, input logic [31:0] hx, input logic [7:0] pt,
                                           input logic [7:0] le, input logic fl, input logic md,
                                           input logic [63:0] rw);
        logic [63:0] f;
        logic [7:0]  b;
        f = '0;
        for (int i = 0; i < nd; i++) begin
            if (le[i] && fl)  b = 8'hFF;
            else if (md)      b = rw[8*i +: 8];
            else              b = ~{pt[i], SEGTAB[hx[4*i +: 4]]};
            f[8*i +: 8] = b;
        end
        return f;
    endfunction

    // Reference model: k is the cycle index within a frame (0 = load, T+1 = latch, -1 = idle).
    initial begin
        int   t;
        logic s, p;
        forever begin
            @(posedge clk);
            cyc++;
            for (int d = 0; d < 2; d++) begin
                s = (d == 0) ? start0 : start1;
                t = 2 * DV[d] * 8 * ND[d];
                if (!rst) begin
                    k[d] = -1;
                    pend[d] = 1'b0;
                end else if (k[d] == -1) begin
                    if (s) k[d] = 0;
                end else begin
                    if (k[d] == 0) begin
                        if (d == 0) frm[d] = encode(8, hexs0, points0, les0, flash0, mode0, raw0);
                        else        frm[d] = encode(4, {16'b0, hexs1}, {4'b0, points1}, {4'b0, les1},
                                                    flash1, mode1, {32'b0, raw1});
                    end
                    p = pend[d] | s;
                    if (k[d] == t + 1) begin
                        k[d] = p ? 0 : -1;
                        pend[d] = 1'b0;
                    end else begin
                        k[d] = k[d] + 1;
                        pend[d] = p;
                    end
                end
            end
        end
    end

    // Compare and capture on the falling edge.
    initial begin
        int         t, j, b;
        logic [4:0] got, exp;
        logic       so, sclk, clrn, dn, eso;
        logic       chk_so;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                got  = (d == 0) ? {busy0, done0, segclk0, segen0, segclrn0}
                                : {busy1, done1, segclk1, segen1, segclrn1};
                so   = (d == 0) ? segsout0 : segsout1;
                sclk = got[2];
                clrn = got[0];
                dn   = got[3];
                t    = 2 * DV[d] * 8 * ND[d];
                chk_so = 1'b0;
                eso    = 1'b0;
                if (!rst) begin
                    exp = 5'b00011;
                    chk_so = 1'b1;
                end else if (k[d] == -1) begin
                    exp = 5'b00011;
                end else if (k[d] == 0) begin
                    exp = 5'b10000;
                end else if (k[d] <= t) begin
                    j = k[d] - 1;
                    b = j / (2 * DV[d]);
                    exp = {1'b1, 1'b0, ((j % (2 * DV[d])) >= DV[d]), 1'b0, 1'b1};
                    chk_so = 1'b1;
                    eso = (DR[d] != 0) ? frm[d][8*ND[d]-1-b] : frm[d][b];
                end else begin
                    exp = 5'b11011;
                end
                check("outs", d, {59'b0, got}, {59'b0, exp});
                if (chk_so) check("segsout", d, {63'b0, so}, {63'b0, eso});

                if (rst) begin
                    if (!clrn) begin
                        cnt[d] = 0;
                        cap[d] = '0;
                    end else if (!pclk[d] && sclk) begin
                        if (DR[d] != 0)    cap[d] = {cap[d][62:0], so};
                        else if (cnt[d] < 64) cap[d][cnt[d]] = so;
                        cnt[d]++;
                    end
                    if (dn) begin
                        ndone[d]++;
                        done_cyc[d] = cyc;
                        last[d] = cap[d];
                    end
                end
                pclk[d] = sclk;
            end
        end
    end

    task automatic pulse(input int d, output int t0);
        @(posedge clk); #1;
        if (d == 0) start0 = 1'b1; else start1 = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic wait_done(input int d, input int n0, input int budget);
        int c;
        c = 0;
        while (ndone[d] <= n0 && c < budget) begin
            @(posedge clk);
            c++;
        end
        check("done_wait", d, {63'b0, ndone[d] > n0}, 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int          t0, n0;
        logic [63:0] r64;
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", 0, {58'b0, busy0, done0, segclk0, segsout0, segen0, segclrn0}, 64'b000011);
        check("reset_state", 1, {58'b0, busy1, done1, segclk1, segsout1, segen1, segclrn1}, 64'b000011);
        @(posedge clk); #1 rst = 1'b1;

        // Plain hex frame on default config
        hexs0 = 32'h0123_4567;
        n0 = ndone[0];
        pulse(0, t0);
        wait_done(0, n0, 400);
        check("hex_frame", 0, last[0], 64'hC0F9_A4B0_9992_82F8);
        check("done_cycle", 0, 64'(done_cyc[0] - t0), 64'd258);

        // Decimal point and blink
        points0 = 8'h01; les0 = 8'h80; flash0 = 1'b1;
        n0 = ndone[0];
        pulse(0, t0);
        wait_done(0, n0, 400);
        check("dp_digit0", 0, {56'b0, last[0][7:0]}, 64'h78);
        check("blank_digit7", 0, {56'b0, last[0][63:56]}, 64'hFF);
        points0 = '0; les0 = '0; flash0 = 1'b0;

        // Raw mode, LSB-first, 4 digits, fast clock
        r64 = 64'h0011_2233_4455_6677;
        raw1 = r64[31:0];
        mode1 = 1'b1;
        n0 = ndone[1];
        pulse(1, t0);
        wait_done(1, n0, 200);
        check("raw_frame", 1, {32'b0, last[1][31:0]}, 64'h4455_6677);
        check("done_cycle", 1, 64'(done_cyc[1] - t0), 64'd66);

        // Three starts mid-frame collapse into one extra frame
        n0 = ndone[0];
        pulse(0, t0);
        repeat (20) @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            repeat (10) @(posedge clk);
            #1 start0 = 1'b1;
            @(posedge clk);
            #1 start0 = 1'b0;
        end
        hexs0 = 32'h89AB_CDEF;
        wait_done(0, n0, 400);
        check("pend_first", 0, last[0], 64'hC0F9_A4B0_9992_82F8);
        #1;
        check("load_after_latch", 0, {62'b0, busy0, segclrn0}, 64'b10);
        wait_done(0, n0 + 1, 400);
        check("pend_second", 0, last[0], 64'h8090_8883_C6A1_868E);
        repeat (600) @(posedge clk);
        #1;
        check("pend_count", 0, 64'(ndone[0] - n0), 64'd2);

        // Asynchronous reset in the middle of bit 20
        n0 = ndone[0];
        pulse(0, t0);
        while (cyc < t0 + 85) begin
            @(posedge clk); #1;
        end
        #2 rst = 1'b0;
        #1;
        check("async_reset", 0, {58'b0, busy0, done0, segclk0, segsout0, segen0, segclrn0}, 64'b000011);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        check("no_done_on_abort", 0, 64'(ndone[0] - n0), 64'd0);
        hexs0 = 32'hFEDC_BA98;
        n0 = ndone[0];
        pulse(0, t0);
        wait_done(0, n0, 400);
        check("after_reset_frame", 0, last[0], 64'h8E86_A1C6_8388_9080);

        // Randomised traffic on both configurations
        for (int i = 0; i < 2500; i++) begin
            @(posedge clk); #1;
            start0  = ($urandom_range(0, 15) == 0);
            start1  = ($urandom_range(0, 15) == 0);
            mode0   = 1'($urandom);
            mode1   = 1'($urandom);
            hexs0   = $urandom;
            hexs1   = 16'($urandom);
            points0 = 8'($urandom);
            points1 = 4'($urandom);
            les0    = 8'($urandom);
            les1    = 4'($urandom);
            flash0  = 1'($urandom);
            flash1  = 1'($urandom);
            raw0    = {$urandom, $urandom};
            raw1    = $urandom;
        end
        @(posedge clk); #1;
        start0 = 1'b0;
        start1 = 1'b0;
        repeat (700) @(posedge clk);
        #1;
        check("drain_idle", 0, {62'b0, busy0, busy1}, 64'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
